cbi980_tx_serializer: RTL and testbench

//  Serial transmit engine of the CBI980 codec interface. Drains the two TX channel FIFOs
//  (ch1/ch0, fed through DOUT1R/DOUT0R) one word per slot. Drives bclk, lrclk and sdout

---
 rtl/cbi980_pkg.sv | 57 +++++
 rtl/cbi980_bclk_gen.sv | 35 +++
 rtl/cbi980_tx_serializer.sv | 174 +++++++++++++++++
 tb/tb_cbi980_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbi980_pkg.sv
// Shared CBI980 definitions: register map, LCFR field layout, slot geometry,
// serializer config/debug structs and sample-width helpers.
package cbi980_pkg;

  localparam int SLOT_W  = 32;
  localparam int DATA_W  = 32;
  localparam int FRAME_W = 2 * SLOT_W;

  localparam logic [7:0] CVR_ADDR    = 8'h00;
  localparam logic [7:0] CR_ADDR     = 8'h04;
  localparam logic [7:0] SR_ADDR     = 8'h08;
  localparam logic [7:0] LCFR_ADDR   = 8'h0C;
  localparam logic [7:0] DOUT1R_ADDR = 8'h10;
  localparam logic [7:0] DOUT0R_ADDR = 8'h14;
  localparam logic [7:0] DIN1R_ADDR  = 8'h18;
  localparam logic [7:0] DIN0R_ADDR  = 8'h1C;

  localparam int LCFR_MCLK_RATE_OFF = 0;
  localparam int LCFR_MCLK_RATE_W   = 3;
  localparam int LCFR_OCTET_CNT_OFF = 4;
  localparam int LCFR_OCTET_CNT_W   = 3;
  localparam int LCFR_RJUST_OFF     = 8;
  localparam int LCFR_LSB_FIRST_OFF = 9;

  typedef struct packed {
    logic [LCFR_MCLK_RATE_W-1:0] mclk_rate;
    logic [LCFR_OCTET_CNT_W-1:0] octet_cnt;
    logic                        rjust;
    logic                        lsb_first;
  } tx_cfg_t;

  typedef struct packed {
    logic [1:0] state;
    logic [5:0] bit_cnt;
    logic       fall_stb;
    logic       rise_stb;
  } tx_dbg_t;

  // Sample width in bits; 0 and anything above 4 octets mean a full 32-bit sample.
  function automatic logic [5:0] octet_bits(input logic [2:0] octet_cnt);
    logic [5:0] n;
    case (octet_cnt)
      3'd1:    n = 6'd8;
      3'd2:    n = 6'd16;
      3'd3:    n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

endpackage

// File: rtl/cbi980_bclk_gen.sv
// Bit-clock divider: bclk half-period is mclk_rate+1 clk cycles while run is high;
// strobes flag the clk cycle whose closing edge makes bclk fall or rise.
module cbi980_bclk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] mclk_rate,
  output logic       bclk,
  output logic       fall_stb,
  output logic       rise_stb
);

  logic [2:0] div_cnt;
  logic       term;

  assign term     = run && (div_cnt >= mclk_rate);
  assign fall_stb = term && bclk;
  assign rise_stb = term && !bclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/cbi980_tx_serializer.sv
// CBI980 transmit serializer: 2-slot x 32-bit frames from the ch0/ch1 TX FIFOs.
// Optional build macro CBI980_TX_REPEAT_EN: underflowed slots repeat the channel's last word.
module cbi980_tx_serializer
  import cbi980_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              txen,
  input  logic [2:0]        mclk_rate,
  input  logic [2:0]        octet_cnt,
  input  logic              rjust,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdout,
  output logic [1:0]        tx_unf,
  output logic              busy,
  output tx_dbg_t           dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic        sdout_q;
  tx_cfg_t     cfg_q;
  tx_cfg_t     cfg_live;

  logic        run;
  logic        fall_stb;
  logic        rise_stb;
  logic        frame_end;
  logic        start_load;
  logic        wrap_load;
  logic        mid_load;
  logic        frame_load;
  logic        load;
  logic        load_ch;

  logic [2:0]  eff_octet;
  logic        eff_rjust;
  logic        eff_lsb;
  logic        valid_sel;
  logic [31:0] data_sel;
  logic [31:0] fill_word;
  logic [31:0] raw_word;
  logic [31:0] slot_word;
  logic [5:0]  n_bits;
  logic [5:0]  pad;
  logic [31:0] sample;

  cbi980_bclk_gen u_bclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mclk_rate (cfg_q.mclk_rate),
    .bclk      (bclk),
    .fall_stb  (fall_stb),
    .rise_stb  (rise_stb)
  );

  assign run        = (state != ST_IDLE);
  assign frame_end  = fall_stb && (bit_cnt == 6'd63);
  // rst term keeps the combinational pop/underflow strobes quiet while reset is held.
  assign start_load = rst && (state == ST_IDLE) && txen;
  assign wrap_load  = frame_end && txen;
  assign mid_load   = fall_stb && (bit_cnt == 6'd31);
  assign frame_load = start_load || wrap_load;
  assign load       = frame_load || mid_load;
  assign load_ch    = mid_load;

  assign cfg_live  = {mclk_rate, octet_cnt, rjust, lsb_first};
  assign eff_octet = frame_load ? octet_cnt : cfg_q.octet_cnt;
  assign eff_rjust = frame_load ? rjust     : cfg_q.rjust;
  assign eff_lsb   = frame_load ? lsb_first : cfg_q.lsb_first;

  assign valid_sel = load_ch ? ch1_valid : ch0_valid;
  assign data_sel  = load_ch ? ch1_data  : ch0_data;

`ifdef CBI980_TX_REPEAT_EN
  logic [31:0] last0;
  logic [31:0] last1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last0 <= '0;
      last1 <= '0;
    end else begin
      if (ch0_ready) last0 <= ch0_data;
      if (ch1_ready) last1 <= ch1_data;
    end
  end

  assign fill_word = load_ch ? last1 : last0;
`else
  assign fill_word = '0;
`endif

  assign raw_word = valid_sel ? data_sel : fill_word;

  // slot_word[31] is slot bit 0, so the shifter always sends its MSB first.
  always_comb begin
    n_bits = octet_bits(eff_octet);
    pad    = 6'd32 - n_bits;
    sample = raw_word & (32'hFFFF_FFFF >> pad);
    if (eff_lsb) sample = bit_reverse32(sample) >> pad;
    slot_word = eff_rjust ? sample : (sample << pad);
  end

  // Pop handshake: ready is a one-cycle strobe raised only on a load cycle for
  // the slot's channel while its valid is high; a word is taken when valid&ready.
  // On a load cycle with valid low, tx_unf pulses for that channel instead.
  assign ch0_ready = load && !load_ch && ch0_valid;
  assign ch1_ready = load &&  load_ch && ch1_valid;
  assign tx_unf    = {load &&  load_ch && !ch1_valid,
                      load && !load_ch && !ch0_valid};

  assign lrclk = bit_cnt[5];
  assign sdout = sdout_q;
  assign busy  = run;
  assign dbg   = '{state: state, bit_cnt: bit_cnt, fall_stb: fall_stb, rise_stb: rise_stb};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      sdout_q <= 1'b0;
      cfg_q   <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (txen) state <= ST_RUN;
        ST_RUN: begin
          if (frame_end && !txen) state <= ST_IDLE;
          else if (!txen)         state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (frame_end) state <= txen ? ST_RUN : ST_IDLE;
          else if (txen) state <= ST_RUN;
        end
        default:  state <= ST_IDLE;
      endcase

      if (frame_load) cfg_q <= cfg_live;

      if (start_load)    bit_cnt <= '0;
      else if (fall_stb) bit_cnt <= bit_cnt + 6'd1;

      if (load) begin
        sdout_q <= slot_word[31];
        shreg   <= {slot_word[30:0], 1'b0};
      end else if (fall_stb) begin
        sdout_q <= shreg[31];
        shreg   <= {shreg[30:0], 1'b0};
      end

      // Last frame finished with no successor: leave the data line low.
      if (frame_end && !txen) begin
        sdout_q <= 1'b0;
        shreg   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cbi980_tx_serializer.sv
// Directed bench for cbi980_tx_serializer: captures sdout/lrclk at each bclk rise
// and compares slots, pop/underflow strobes and idle/reset outputs to hand values.
module tb_cbi980_tx_serializer;
  import cbi980_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        txen = 1'b0;
  logic [2:0]  mclk_rate = 3'd0;
  logic [2:0]  octet_cnt = 3'd4;
  logic        rjust = 1'b0;
  logic        lsb_first = 1'b0;
  logic [31:0] ch0_data = '0;
  logic        ch0_valid = 1'b0;
  logic        ch0_ready;
  logic [31:0] ch1_data = '0;
  logic        ch1_valid = 1'b0;
  logic        ch1_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdout;
  logic [1:0]  tx_unf;
  logic        busy;
  tx_dbg_t     dbg;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  cbi980_tx_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .txen      (txen),
    .mclk_rate (mclk_rate),
    .octet_cnt (octet_cnt),
    .rjust     (rjust),
    .lsb_first (lsb_first),
    .ch0_data  (ch0_data),
    .ch0_valid (ch0_valid),
    .ch0_ready (ch0_ready),
    .ch1_data  (ch1_data),
    .ch1_valid (ch1_valid),
    .ch1_ready (ch1_ready),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdout     (sdout),
    .tx_unf    (tx_unf),
    .busy      (busy),
    .dbg       (dbg)
  );

  // monitor: codec-side capture at bclk rise plus strobe counters
  logic cap_bits [0:1023];
  logic cap_lr   [0:1023];
  int   cap_cyc  [0:1023];
  int   cap_n = 0;
  int   cyc = 0;
  int   r0_cnt = 0, r1_cnt = 0, u0_cnt = 0, u1_cnt = 0, both_cnt = 0;
  logic prev_bclk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bclk && !prev_bclk && cap_n < 1024) begin
      cap_bits[cap_n] = sdout;
      cap_lr[cap_n]   = lrclk;
      cap_cyc[cap_n]  = cyc;
      cap_n++;
    end
    prev_bclk = bclk;
    if (ch0_ready) r0_cnt++;
    if (ch1_ready) r1_cnt++;
    if (tx_unf[0]) u0_cnt++;
    if (tx_unf[1]) u1_cnt++;
    if ((ch0_ready || tx_unf[0]) && (ch1_ready || tx_unf[1])) both_cnt++;
  end

  int base, r0b, r1b, u0b, u1b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot_bits(input int b);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 32; k++) if (b + k < 1024) w[31-k] = cap_bits[b+k];
    return w;
  endfunction

  function automatic logic [31:0] lr_bits(input int b);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 32; k++) if (b + k < 1024) w[31-k] = cap_lr[b+k];
    return w;
  endfunction

  // driver tasks
  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base = cap_n;
    r0b = r0_cnt; r1b = r1_cnt; u0b = u0_cnt; u1b = u1_cnt;
  endtask

  task automatic wait_bits(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (cap_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cap_n < target) chk({tag, "_bits_timeout"}, cap_n, target);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic one_frame(input string tag, input int budget);
    at_drive();
    txen = 1'b1;
    at_drive();
    txen = 1'b0;
    wait_idle(tag, budget);
    at_drive();
  endtask

  initial begin
    logic [31:0] exp_unf_word;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bclk, lrclk, sdout, ch1_ready, ch0_ready, tx_unf, busy}, 0);
    chk("reset_state", dbg.state, 0);
    rst = 1'b1;
    at_drive();

    // 1: full 32-bit MSB-first, bclk = clk/2
    mclk_rate = 3'd0; octet_cnt = 3'd4; rjust = 1'b0; lsb_first = 1'b0;
    ch0_data = 32'hA5A50F0F; ch1_data = 32'h12345678;
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    snap();
    one_frame("t1", 400);
    chk("t1_slot0", slot_bits(base), 32'hA5A50F0F);
    chk("t1_slot1", slot_bits(base + 32), 32'h12345678);
    chk("t1_lr0", lr_bits(base), 32'h0);
    chk("t1_lr1", lr_bits(base + 32), 32'hFFFFFFFF);
    chk("t1_period", cap_cyc[base+1] - cap_cyc[base], 2);
    chk("t1_ready0", r0_cnt - r0b, 1);
    chk("t1_ready1", r1_cnt - r1b, 1);
    chk("t1_unf", (u0_cnt - u0b) + (u1_cnt - u1b), 0);
    chk("t1_nbits", cap_n - base, 64);
    chk("t1_idle_outs", {bclk, lrclk, sdout, busy}, 0);

    // 2: 16-bit right-justified, bclk period 8
    mclk_rate = 3'd3; octet_cnt = 3'd2; rjust = 1'b1; lsb_first = 1'b0;
    ch0_data = 32'hFFFFBEEF; ch1_data = 32'h9999CAFE;
    snap();
    one_frame("t2", 1200);
    chk("t2_slot0", slot_bits(base), 32'h0000BEEF);
    chk("t2_slot1", slot_bits(base + 32), 32'h0000CAFE);
    chk("t2_period", cap_cyc[base+1] - cap_cyc[base], 8);

    // 3: 8-bit LSB-first, left-justified
    mclk_rate = 3'd1; octet_cnt = 3'd1; rjust = 1'b0; lsb_first = 1'b1;
    ch0_data = 32'hFFFFFF01; ch1_data = 32'h00000080;
    snap();
    one_frame("t3", 800);
    chk("t3_slot0", slot_bits(base), 32'h80000000);
    chk("t3_slot1", slot_bits(base + 32), 32'h01000000);
    chk("t3_period", cap_cyc[base+1] - cap_cyc[base], 4);

    // 4: ch0 underflow at the second frame start
    mclk_rate = 3'd0; octet_cnt = 3'd4; rjust = 1'b0; lsb_first = 1'b0;
    ch0_data = 32'h11223344; ch1_data = 32'h55667788;
    snap();
    at_drive();
    txen = 1'b1;
    wait_bits("t4a", base + 40, 300);
    at_drive();
    ch0_valid = 1'b0;
    wait_bits("t4b", base + 70, 300);
    at_drive();
    txen = 1'b0;
    wait_idle("t4", 400);
    at_drive();
`ifdef CBI980_TX_REPEAT_EN
    exp_unf_word = 32'h11223344;
`else
    exp_unf_word = 32'h00000000;
`endif
    chk("t4_f1_slot0", slot_bits(base), 32'h11223344);
    chk("t4_f2_slot0", slot_bits(base + 64), exp_unf_word);
    chk("t4_f2_slot1", slot_bits(base + 96), 32'h55667788);
    chk("t4_ready0", r0_cnt - r0b, 1);
    chk("t4_ready1", r1_cnt - r1b, 2);
    chk("t4_unf0", u0_cnt - u0b, 1);
    chk("t4_unf1", u1_cnt - u1b, 0);
    chk("t4_nbits", cap_n - base, 128);
    ch0_valid = 1'b1;

    // 5: txen dropped near bit 10; octet change only hits the next frame
    ch0_data = 32'hDEADBEEF; ch1_data = 32'h0F0F0F0F;
    snap();
    at_drive();
    txen = 1'b1;
    wait_bits("t5a", base + 10, 200);
    at_drive();
    txen = 1'b0;
    octet_cnt = 3'd1;
    wait_idle("t5", 400);
    at_drive();
    chk("t5_slot0", slot_bits(base), 32'hDEADBEEF);
    chk("t5_slot1", slot_bits(base + 32), 32'h0F0F0F0F);
    chk("t5_ready1", r1_cnt - r1b, 1);
    chk("t5_nbits", cap_n - base, 64);
    chk("t5_idle_outs", {bclk, lrclk, sdout, busy}, 0);
    snap();
    one_frame("t5b", 400);
    chk("t5_next_slot0", slot_bits(base), 32'hEF000000);
    chk("t5_next_slot1", slot_bits(base + 32), 32'h0F000000);

    // 6: asynchronous reset mid-frame, restart from the ch0 slot
    octet_cnt = 3'd4;
    ch0_data = 32'h13579BDF; ch1_data = 32'h2468ACE0;
    snap();
    at_drive();
    txen = 1'b1;
    wait_bits("t6a", base + 41, 300);
    at_drive();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_outs", {bclk, lrclk, sdout, ch1_ready, ch0_ready, tx_unf, busy}, 0);
    chk("t6_async_cnt", {dbg.state, dbg.bit_cnt}, 0);
    repeat (2) @(posedge clk);
    #3;
    snap();
    rst = 1'b1;
    wait_bits("t6b", base + 32, 200);
    chk("t6_restart_slot0", slot_bits(base), 32'h13579BDF);
    chk("t6_restart_lr0", lr_bits(base), 32'h0);
    at_drive();
    txen = 1'b0;
    wait_idle("t6", 400);
    at_drive();
    chk("t6_restart_slot1", slot_bits(base + 32), 32'h2468ACE0);
    chk("t6_ready0", r0_cnt - r0b, 1);
    chk("t6_ready1", r1_cnt - r1b, 1);

    chk("no_dual_channel_strobe", both_cnt, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
